// File: rtl/sorted_stream_tx_if.sv
// Word stream from the sorter transmit end to a narrow downstream consumer.
// Latency: none (wires only).
// Backpressure: the consumer drives tx_ready; the producer holds tx_data/tx_last while tx_valid && !tx_ready.
//
// Signals:
//   tx_data  - current word (WIDTH bits)
//   tx_valid - tx_data is valid
//   tx_ready - consumer accepts; a transfer happens on tx_valid && tx_ready
//   tx_last  - marks the final (4th) word of a frame
interface sorted_stream_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_last;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/sorted_stream_tx.sv
// Captures the four outputs of the parallel sorter SORT_LAT cycles after load and streams them o1..o4.
// Latency: first word valid right after edge E0+SORT_LAT; one frame per SORT_LAT+5 cycles.
// Backpressure: tx_ready stalls SEND with data/last held; load is taken only in IDLE, else overrun is set.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   load / in_ready   - frame start; accepted when load && in_ready (in_ready high only in IDLE)
//   o1..o4            - sorter outputs, sampled at edge E0+SORT_LAT
//   tx                - master side of sorted_stream_tx_if (tx_data/tx_valid/tx_ready/tx_last)
//   overrun           - sticky: load seen while busy; cleared only by reset
//   order_err         - capture saw o1..o4 out of signed order
//
// Optional build macro SORTED_STREAM_TX_ORDER_CHECK_EN enables the order check; without it
// order_err is tied low and no comparators exist.
module sorted_stream_tx #(
    parameter int WIDTH    = 8,
    parameter int SORT_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    output logic             in_ready,
    input  logic [WIDTH-1:0] o1,
    input  logic [WIDTH-1:0] o2,
    input  logic [WIDTH-1:0] o3,
    input  logic [WIDTH-1:0] o4,
    output logic             overrun,
    output logic             order_err,
    sorted_stream_tx_if.master tx
);

    if (SORT_LAT < 1 || SORT_LAT > 15) begin : g_bad_lat
        $error("sorted_stream_tx: SORT_LAT must be in 1..15");
    end

    localparam logic [3:0] CNT_INIT = 4'(SORT_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       cnt;
    logic [1:0]       idx;
    logic [WIDTH-1:0] data_buf [4];

    logic accept;
    logic capture;
    logic xfer;

    assign accept  = load && (state == S_IDLE);
    assign capture = (state == S_WAIT) && (cnt == 4'd0);
    assign xfer    = (state == S_SEND) && tx.tx_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load)                  state_nxt = S_WAIT;
            S_WAIT:  if (cnt == 4'd0)           state_nxt = S_SEND;
            S_SEND:  if (xfer && idx == 2'd3)   state_nxt = S_IDLE;
            default:                            state_nxt = S_IDLE;
        endcase
    end

    // Outputs decode registered state only, so tx_ready never reaches tx_valid combinationally.
    always_comb begin
        in_ready    = (state == S_IDLE);
        tx.tx_valid = (state == S_SEND);
        tx.tx_last  = (state == S_SEND) && (idx == 2'd3);
        tx.tx_data  = (state == S_SEND) ? data_buf[idx] : '0;
    end

    // Latency counter, word index and holding buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
            idx <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                data_buf[i] <= '0;
            end
        end else begin
            if (accept) begin
                cnt <= CNT_INIT;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (capture) begin
                data_buf[0] <= o1;
                data_buf[1] <= o2;
                data_buf[2] <= o3;
                data_buf[3] <= o4;
                idx         <= 2'd0;
            end else if (xfer && idx != 2'd3) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // A load while busy never disturbs the frame, it only leaves this sticky marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (load && state != S_IDLE) begin
            overrun <= 1'b1;
        end
    end

`ifdef SORTED_STREAM_TX_ORDER_CHECK_EN
    logic order_bad;
    logic order_err_q;

    assign order_bad = !(($signed(o1) <= $signed(o2)) &&
                         ($signed(o2) <= $signed(o3)) &&
                         ($signed(o3) <= $signed(o4)));

    // Accept and capture never coincide, so clear-then-set has no priority conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            order_err_q <= 1'b0;
        end else if (accept) begin
            order_err_q <= 1'b0;
        end else if (capture && order_bad) begin
            order_err_q <= 1'b1;
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sorted_stream_tx.sv
// Bench for sorted_stream_tx: two instances (SORT_LAT=2 and SORT_LAT=1) against a frame-level model.
// Latency: model expects capture SORT_LAT edges after an accepted load, first word visible right after.
// Backpressure: tx_ready is driven directed and random; the model only advances a word on valid && ready.
module tb_sorted_stream_tx;

    localparam int W = 8;
`ifdef SORTED_STREAM_TX_ORDER_CHECK_EN
    localparam bit ORDER_ON = 1'b1;
`else
    localparam bit ORDER_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   ld, rdy, in_rdy, ovr, oerr, vld, lst;
    logic [W-1:0] o_in [2][4];
    logic [W-1:0] dat  [2];

    sorted_stream_tx_if #(.WIDTH(W)) sif0 ();
    sorted_stream_tx_if #(.WIDTH(W)) sif1 ();

    assign sif0.tx_ready = rdy[0];
    assign sif1.tx_ready = rdy[1];
    assign vld    = {sif1.tx_valid, sif0.tx_valid};
    assign lst    = {sif1.tx_last,  sif0.tx_last};
    assign dat[0] = sif0.tx_data;
    assign dat[1] = sif1.tx_data;

    sorted_stream_tx #(.WIDTH(W), .SORT_LAT(2)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ld[0]),
        .in_ready  (in_rdy[0]),
        .o1        (o_in[0][0]),
        .o2        (o_in[0][1]),
        .o3        (o_in[0][2]),
        .o4        (o_in[0][3]),
        .overrun   (ovr[0]),
        .order_err (oerr[0]),
        .tx        (sif0.master)
    );

    sorted_stream_tx #(.WIDTH(W), .SORT_LAT(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ld[1]),
        .in_ready  (in_rdy[1]),
        .o1        (o_in[1][0]),
        .o2        (o_in[1][1]),
        .o3        (o_in[1][2]),
        .o4        (o_in[1][3]),
        .overrun   (ovr[1]),
        .order_err (oerr[1]),
        .tx        (sif1.master)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Frame-level model: a frame is busy from its accepted load until its 4th word is taken.
    bit           busy [2];
    int           cd   [2];
    logic [W-1:0] ew   [2][4];
    int           en   [2];
    int           ep   [2];
    bit           mo   [2];
    bit           me   [2];
    bit           p5 = 1'b0;
    int           last_cyc1 = -1;
    int           nper = 0;
    int           vcnt0 = 0;

    function automatic bit out_of_order(input int d);
        return !(($signed(o_in[d][0]) <= $signed(o_in[d][1])) &&
                 ($signed(o_in[d][1]) <= $signed(o_in[d][2])) &&
                 ($signed(o_in[d][2]) <= $signed(o_in[d][3])));
    endfunction

    task automatic model_step(input int d);
        int sl;
        bit acc;
        sl = (d == 0) ? 2 : 1;
        if (!rst_n) begin
            check($sformatf("d%0d_rst_valid", d),   vld[d],    1'b0);
            check($sformatf("d%0d_rst_in_ready", d), in_rdy[d], 1'b1);
            check($sformatf("d%0d_rst_overrun", d), ovr[d],    1'b0);
            check($sformatf("d%0d_rst_order", d),   oerr[d],   1'b0);
            check($sformatf("d%0d_rst_data", d),    dat[d],    '0);
            busy[d] = 0; cd[d] = 0; en[d] = 0; ep[d] = 0; mo[d] = 0; me[d] = 0;
            return;
        end
        check($sformatf("d%0d_in_ready", d),  in_rdy[d], !busy[d]);
        check($sformatf("d%0d_valid", d),     vld[d],    en[d] > 0);
        check($sformatf("d%0d_overrun", d),   ovr[d],    mo[d]);
        check($sformatf("d%0d_order_err", d), oerr[d],   me[d]);
        if (en[d] > 0) begin
            check($sformatf("d%0d_data", d), dat[d], ew[d][ep[d]]);
            check($sformatf("d%0d_last", d), lst[d], ep[d] == 3);
            if (d == 0) vcnt0++;
        end
        // Advance the model across the coming rising edge.
        acc = 0;
        if (ld[d]) begin
            if (busy[d]) begin
                mo[d] = 1;
            end else begin
                acc = 1; busy[d] = 1; cd[d] = sl; me[d] = 0;
            end
        end
        if (en[d] > 0) begin
            if (rdy[d]) begin
                if (ep[d] == 3) begin
                    busy[d] = 0;
                    if (d == 1 && p5) begin
                        if (last_cyc1 >= 0) begin
                            check("t5_frame_period", cyc - last_cyc1, 6);
                            nper++;
                        end
                        last_cyc1 = cyc;
                    end
                end
                ep[d]++;
                en[d]--;
            end
        end else if (busy[d] && !acc && cd[d] > 0) begin
            cd[d]--;
            if (cd[d] == 0) begin
                for (int k = 0; k < 4; k++) ew[d][k] = o_in[d][k];
                en[d] = 4;
                ep[d] = 0;
                me[d] = ORDER_ON && out_of_order(d);
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0);
        model_step(1);
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_o(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] e);
        o_in[d][0] = a; o_in[d][1] = b; o_in[d][2] = c; o_in[d][3] = e;
    endtask

    task automatic rand_o(input int d);
        for (int k = 0; k < 4; k++) o_in[d][k] = W'($urandom);
    endtask

    initial begin
        ld = '0; rdy = '0;
        set_o(0, 0, 0, 0, 0);
        set_o(1, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // 1: signed edge values, ready held high
        set_o(0, 8'h80, 8'hD8, 8'h7F, 8'h80);
        rdy[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ld[0] = (i == 0);
            step();
        end
        check("t1_order_err", oerr[0], ORDER_ON);

        // 2: sorted frame, ready toggling so the first SEND cycle stalls
        set_o(0, 8'd1, 8'd2, 8'd3, 8'd4);
        vcnt0 = 0;
        for (int i = 0; i < 14; i++) begin
            ld[0]  = (i == 0);
            rdy[0] = (i % 2 == 0);
            step();
        end
        check("t2_send_cycles", vcnt0, 8);
        check("t2_order_err", oerr[0], 1'b0);

        // 3: extra loads during WAIT and during SEND
        rdy[0] = 1'b1;
        set_o(0, 8'h10, 8'h20, 8'h30, 8'h40);
        for (int i = 0; i < 12; i++) begin
            ld[0] = (i == 0 || i == 1 || i == 4);
            if (i == 1) set_o(0, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
            step();
        end
        check("t3_overrun_sticky", ovr[0], 1'b1);

        // 4: asynchronous reset after two transfers
        set_o(0, 8'h05, 8'h06, 8'h07, 8'h08);
        for (int i = 0; i < 5; i++) begin
            ld[0] = (i == 0);
            step();
        end
        rst_n = 1'b0;
        #1;
        check("t4_async_valid", vld[0], 1'b0);
        check("t4_async_in_ready", in_rdy[0], 1'b1);
        check("t4_async_overrun", ovr[0], 1'b0);
        ld[0] = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        set_o(0, 8'hF0, 8'hF1, 8'h00, 8'h01);
        vcnt0 = 0;
        for (int i = 0; i < 10; i++) begin
            ld[0] = (i == 0);
            step();
        end
        check("t4_refill_words", vcnt0, 4);

        // 5: back-to-back frames on the SORT_LAT=1 instance
        p5 = 1'b1;
        last_cyc1 = -1;
        nper = 0;
        rdy[1] = 1'b1;
        for (int i = 0; i < 70; i++) begin
            ld[1] = in_rdy[1];
            rand_o(1);
            step();
        end
        ld[1] = 1'b0;
        repeat (8) step();
        p5 = 1'b0;
        check("t5_period_count", nper >= 9, 1'b1);

        // Random traffic on both instances
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < 2; d++) begin
                ld[d]  = ($urandom_range(0, 3) == 0);
                rdy[d] = ($urandom_range(0, 9) < 7);
                rand_o(d);
            end
            step();
        end
        ld  = '0;
        rdy = '1;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sorted_stream_tx.md
# sorted_stream_tx

- Transmit end of the 4-input parallel sorter.
- After the sorter's inputs are applied and a `load` pulse is given, the block:
  - waits a fixed sorter latency;
  - captures the four sorted outputs `o1`..`o4` into a holding buffer;
  - streams them out one word per transfer over a valid/ready interface, `o1` first, marking the final word.
- It lets the sorter output feed a narrow downstream consumer with back-pressure.

## Interface

Parameters:
- `WIDTH`, 8: word width; matches the sorter data width.
- `SORT_LAT`, 2: cycles from the accepted `load` to a valid sorter output. Legal range 1..15.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: start a frame; the sorter inputs are applied this cycle.
- `in_ready` out 1: high only in IDLE; `load` is accepted when `load && in_ready`.
- `o1`,`o2`,`o3`,`o4` in WIDTH each: sorter outputs.
- `tx_data` out WIDTH: current word.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: downstream accepts; a transfer happens when `tx_valid && tx_ready`.
- `tx_last` out 1: high with the 4th word of a frame.
- `overrun` out 1: sticky flag, set when `load` arrives while `in_ready=0`.
- `order_err` out 1: sorted-order check failed (see Configuration).

## Operation

- FSM states: IDLE, WAIT, SEND.
- **IDLE**
  - `in_ready=1`.
  - An accepted `load` loads `cnt <= SORT_LAT-1`, then goes to WAIT.
- **WAIT**
  - If `cnt != 0`: decrement `cnt`.
  - If `cnt == 0`: capture `o1..o4` into `buf[0..3]`, set `idx <= 0`, go to SEND.
- **SEND**
  - `tx_valid=1`, `tx_data=buf[idx]`, `tx_last=(idx==3)`.
  - On a transfer with `idx<3`: `idx++`.
  - On a transfer with `idx==3`: go to IDLE.
- Back-pressure: while `tx_valid && !tx_ready`, `tx_data` and `tx_last` hold stable. `tx_valid` never drops before its transfer.
- `tx_ready` is ignored outside SEND.
- `load` outside IDLE:
  - the frame is not restarted and `buf` is not modified;
  - `overrun` is set.
  - `overrun` clears only on reset.
- Data is passed through bit-exact; no arithmetic is done on the payload.
- Reset (asynchronous assert, any state): FSM to IDLE, `cnt`/`idx`/`buf` cleared, and output reset values are:
  - `in_ready=1`
  - `tx_valid=0`, `tx_last=0`, `tx_data=0`
  - `overrun=0`, `order_err=0`
- Reset mid-frame discards the frame; no partial words are emitted afterwards.

## Timing

- `load` is accepted at edge E0. The sorter outputs are sampled at edge E0+SORT_LAT.
- `tx_valid` rises right after E0+SORT_LAT.
- Best-case frame with `tx_ready` held high:
  - 4 transfers on edges E0+SORT_LAT+1 .. E0+SORT_LAT+4;
  - `in_ready` is high after the last edge;
  - the next `load` is accepted one cycle later at the earliest.
- Throughput: one frame per SORT_LAT+5 cycles.
- All outputs are registered or decoded from registered state only; no combinational path from `tx_ready` to `tx_valid`.

## Configuration

- Macro: `SORTED_STREAM_TX_ORDER_CHECK_EN`.
- **Defined:**
  - At capture, the block checks `o1<=o2<=o3<=o4` as signed two's-complement WIDTH-bit values.
  - On violation, `order_err` is set on the capture edge.
  - It stays set until the next accepted `load`, or reset.
  - The frame is still transmitted unchanged.
- **Undefined:** `order_err` is tied to 0, and no comparator logic is generated.

## Test plan

1. Reset, then sorter outputs -128,-40,127,-128, `tx_ready=1`, `load` pulse, SORT_LAT=2 → expect:
   - `tx_data` 8'h80,8'hD8,8'h7F,8'h80 on 4 consecutive cycles starting 3 cycles after `load`;
   - `tx_last` only on the 4th;
   - `order_err=1` with the macro, 0 without.
2. Sorted input 1,2,3,4 with `tx_ready` toggling 1/0 every cycle → expect:
   - words 1,2,3,4 in order;
   - `tx_data` stable while stalled;
   - 8 SEND cycles;
   - `order_err=0`.
3. Second `load` during WAIT and again during SEND → expect:
   - the frame is unchanged;
   - `overrun=1` and stays 1 after the frame;
   - `in_ready=0` throughout.
4. `rst_n` asserted asynchronously mid-SEND after 2 transfers → expect:
   - `tx_valid=0`, `in_ready=1`, `overrun=0` immediately;
   - no further words;
   - a new `load` then produces a full 4-word frame.
5. Back-to-back frames with `load` raised on the first cycle `in_ready=1`, SORT_LAT=1 → expect:
   - the frame period is exactly 6 cycles;
   - no dropped or duplicated words.
